ddr_rd_tracker: RTL and testbench

DDR_RD_TRACKER -- requirements
Module: ddr_rd_tracker

---
 rtl/ddr_rd_tracker.sv | 177 +++++++++++++++++
 tb/tb_ddr_rd_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_tracker.sv
// DDR read tracker: queues read addresses toward the controller and turns the
// returned beats into complete bursts, each tagged with its address.

module ddr_rd_tracker_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full, do_push, do_pop;

  // The extra pointer bit tells a full queue apart from an empty one.
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end
endmodule

// state   | meaning
// IDLE    | waiting for the first beat of a burst
// COLLECT | beat 0 captured, gathering the remaining beats at idx
module ddr_rd_tracker #(
  parameter int ADDR_W = 27,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 2,
  parameter int DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_W-1:0]       read_address,
  input  logic                    read_req,
  output logic                    read_allowed,
  output logic                    reads_pending,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic [ADDR_W-1:0]       f2a_app_adx,
  output logic                    f2a_has_rd_req,
  input  logic                    f2a_get_rd_adr,
  input  logic                    app_rd_data_valid,
  input  logic [BEAT_W-1:0]       app_rd_data,
  output logic [BEATS*BEAT_W-1:0] return_data,
  output logic [ADDR_W-1:0]       return_adx,
  output logic                    return_data_available,
  input  logic                    get_return_data,
  output logic                    err_unexpected
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W  = 3;
  localparam int DATA_W = BEATS * BEAT_W;
  localparam int RET_W  = ADDR_W + DATA_W;

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, idx_sel;
  logic [DATA_W-1:0]  beat_buf, beat_nxt, beat_ins;
  logic               ret_push, err_set, accept, ret_pop;
  logic               pend_empty, disp_empty, ret_empty;
  logic [ADDR_W-1:0]  pend_head;
  logic [RET_W-1:0]   ret_dout;

  assign read_allowed = (outstanding < CNT_W'(DEPTH));
  assign accept       = read_req && read_allowed;
  assign ret_pop      = get_return_data && !ret_empty;

  ddr_rd_tracker_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_disp_q (
    .clk(clk), .resetn(resetn), .push(accept), .din(read_address),
    .pop(f2a_get_rd_adr), .dout(f2a_app_adx), .empty(disp_empty)
  );

  ddr_rd_tracker_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pend_q (
    .clk(clk), .resetn(resetn), .push(accept), .din(read_address),
    .pop(ret_push), .dout(pend_head), .empty(pend_empty)
  );

  // Occupancy is bounded by outstanding, so this queue cannot overflow.
  ddr_rd_tracker_fifo #(.W(RET_W), .DEPTH(DEPTH)) u_ret_q (
    .clk(clk), .resetn(resetn), .push(ret_push), .din({pend_head, beat_ins}),
    .pop(get_return_data), .dout(ret_dout), .empty(ret_empty)
  );

  assign f2a_has_rd_req        = !disp_empty;
  assign reads_pending         = !pend_empty;
  assign return_data_available = !ret_empty;
  assign return_adx            = ret_dout[RET_W-1 -: ADDR_W];
  assign return_data           = ret_dout[DATA_W-1:0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    beat_nxt  = beat_buf;
    ret_push  = 1'b0;
    err_set   = 1'b0;
    idx_sel   = (state == S_IDLE) ? '0 : idx;
    beat_ins  = beat_buf;
    for (int i = 0; i < BEATS; i++) begin
      if (idx_sel == IDX_W'(i)) beat_ins[i*BEAT_W +: BEAT_W] = app_rd_data;
    end
    case (state)
      S_IDLE: begin
        if (app_rd_data_valid) begin
          if (pend_empty) begin
            err_set = 1'b1;
          end else begin
            beat_nxt = beat_ins;
            if (BEATS == 1) begin
              ret_push = 1'b1;
            end else begin
              state_nxt = S_COLLECT;
              idx_nxt   = IDX_W'(1);
            end
          end
        end
      end
      S_COLLECT: begin
        if (app_rd_data_valid) begin
          beat_nxt = beat_ins;
          if (idx == IDX_W'(BEATS - 1)) begin
            ret_push  = 1'b1;
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= S_IDLE;
      idx            <= '0;
      beat_buf       <= '0;
      err_unexpected <= 1'b0;
      outstanding    <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      beat_buf <= beat_nxt;
      if (err_set) err_unexpected <= 1'b1;
      case ({accept, ret_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_rd_tracker.sv
// Directed bench for ddr_rd_tracker at default parameters; expected values
// are written out by hand next to each stimulus step.

module tb_ddr_rd_tracker;
  localparam int ADDR_W = 27;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 2;
  localparam int DEPTH  = 64;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [ADDR_W-1:0]       read_address;
  logic                    read_req;
  logic                    read_allowed;
  logic                    reads_pending;
  logic [6:0]              outstanding;
  logic [ADDR_W-1:0]       f2a_app_adx;
  logic                    f2a_has_rd_req;
  logic                    f2a_get_rd_adr;
  logic                    app_rd_data_valid;
  logic [BEAT_W-1:0]       app_rd_data;
  logic [BEATS*BEAT_W-1:0] return_data;
  logic [ADDR_W-1:0]       return_adx;
  logic                    return_data_available;
  logic                    get_return_data;
  logic                    err_unexpected;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [63:0] BA = 64'h1111_1111_1111_1111;
  localparam logic [63:0] BB = 64'h2222_2222_2222_2222;
  localparam logic [63:0] BC = 64'hCCCC_0000_1234_5678;
  localparam logic [63:0] BD = 64'hDDDD_1111_8765_4321;
  localparam logic [63:0] BE = 64'hEEEE_EEEE_0000_0001;
  localparam logic [63:0] BF = 64'hFFFF_FFFF_0000_0002;

  always #5 clk = ~clk;

  ddr_rd_tracker #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .read_address(read_address), .read_req(read_req),
    .read_allowed(read_allowed), .reads_pending(reads_pending),
    .outstanding(outstanding),
    .f2a_app_adx(f2a_app_adx), .f2a_has_rd_req(f2a_has_rd_req),
    .f2a_get_rd_adr(f2a_get_rd_adr),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .return_data(return_data), .return_adx(return_adx),
    .return_data_available(return_data_available),
    .get_return_data(get_return_data), .err_unexpected(err_unexpected)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d);
    app_rd_data_valid = 1'b1;
    app_rd_data       = d;
    tick();
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
  endtask

  task automatic request(input logic [ADDR_W-1:0] a);
    read_req     = 1'b1;
    read_address = a;
    tick();
    read_req     = 1'b0;
  endtask

  task automatic pop_ret();
    get_return_data = 1'b1;
    tick();
    get_return_data = 1'b0;
  endtask

  task automatic pop_disp();
    f2a_get_rd_adr = 1'b1;
    tick();
    f2a_get_rd_adr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; read_address = '0; read_req = 1'b0; f2a_get_rd_adr = 1'b0;
    app_rd_data_valid = 1'b0; app_rd_data = '0; get_return_data = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("rst_allowed", read_allowed, 1);
    chk("rst_pending", reads_pending, 0);
    chk("rst_has_rd", f2a_has_rd_req, 0);
    chk("rst_avail", return_data_available, 0);
    chk("rst_err", err_unexpected, 0);
    chk("rst_outst", outstanding, 0);

    // basic burst
    request(27'h0000123);
    chk("b_has_rd", f2a_has_rd_req, 1);
    chk("b_app_adx", f2a_app_adx, 27'h0000123);
    chk("b_outst", outstanding, 1);
    chk("b_pending", reads_pending, 1);
    pop_disp();
    chk("b_disp_empty", f2a_has_rd_req, 0);
    beat(BA);
    chk("b_avail_mid", return_data_available, 0);
    beat(BB);
    chk("b_avail", return_data_available, 1);
    chk("b_data", return_data, {BB, BA});
    chk("b_adx", return_adx, 27'h0000123);
    chk("b_pending_end", reads_pending, 0);
    pop_ret();
    chk("b_outst_pop", outstanding, 0);
    chk("b_avail_pop", return_data_available, 0);

    // gap between beats
    request(27'h0000ABC);
    pop_disp();
    beat(BC);
    for (int i = 0; i < 3; i++) tick();
    chk("g_avail_gap", return_data_available, 0);
    chk("g_pending_gap", reads_pending, 1);
    beat(BD);
    chk("g_avail", return_data_available, 1);
    chk("g_data", return_data, {BD, BC});
    chk("g_adx", return_adx, 27'h0000ABC);
    chk("g_err", err_unexpected, 0);
    pop_ret();
    chk("g_no_extra", return_data_available, 0);

    // unexpected beat
    beat(BA);
    chk("u_err", err_unexpected, 1);
    chk("u_avail", return_data_available, 0);
    chk("u_outst", outstanding, 0);
    tick(); tick();
    chk("u_err_held", err_unexpected, 1);

    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++) request(ADDR_W'(32'h100 + i));
    chk("f_outst", outstanding, 64);
    chk("f_allowed", read_allowed, 0);
    request(27'h0000777);
    chk("f_outst_65", outstanding, 64);
    chk("f_disp_head", f2a_app_adx, 27'h0000100);
    for (int i = 0; i < DEPTH - 1; i++) pop_disp();
    chk("f_disp_last", f2a_app_adx, 27'h000013F);
    pop_disp();
    chk("f_disp_drained", f2a_has_rd_req, 0);
    beat(BE); beat(BF);
    chk("f_ret_adx", return_adx, 27'h0000100);
    chk("f_ret_data", return_data, {BF, BE});
    pop_ret();
    chk("f_outst_pop", outstanding, 63);
    chk("f_allowed_pop", read_allowed, 1);

    // accept and pop together
    beat(BA); beat(BB);
    chk("s_ret_adx", return_adx, 27'h0000101);
    read_req = 1'b1; read_address = 27'h0000200; get_return_data = 1'b1;
    tick();
    read_req = 1'b0; get_return_data = 1'b0;
    chk("s_outst", outstanding, 63);
    chk("s_disp", f2a_app_adx, 27'h0000200);
    chk("s_avail", return_data_available, 0);
    beat(BC); beat(BD);
    chk("s_next_adx", return_adx, 27'h0000102);
    pop_ret();
    chk("s_outst_after", outstanding, 62);

    // reset mid-burst
    beat(BE);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("r_outst", outstanding, 0);
    chk("r_err", err_unexpected, 0);
    chk("r_pending", reads_pending, 0);
    request(27'h0000456);
    beat(BC); beat(BD);
    chk("r_avail", return_data_available, 1);
    chk("r_data", return_data, {BD, BC});
    chk("r_adx", return_adx, 27'h0000456);
    chk("r_err_after", err_unexpected, 0);
    chk("r_outst_after", outstanding, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
